wb_regfile: RTL and testbench

- Writeback end of the MEM/WB pipeline latch, merged with the 32x32 architectural register file.
- Consumes the latched instruction, ALU/PC result, memory data and overflow flag, and decodes the single register write each instruction produces.
- Commits that write on the falling clock edge and serves two combinational read ports to decode, with write-through bypass.
- Keeps a retired-instruction counter for debug and performance measurement.

---
 rtl/wb_regfile_pkg.sv | 46 ++++
 rtl/wb_regfile_decode.sv | 76 +++++++
 rtl/wb_regfile.sv | 80 ++++++++
 tb/tb_wb_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and the decode stage.
// Contents: opcode and ALU-op encodings, RSTATUS exception codes, and a
// helper that maps an overflowing R-type ALU op to its status code.
package wb_regfile_pkg;

  // Primary opcodes, ir[31:27]
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  // R-type ALU ops, ir[6:2]
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Values written to RSTATUS on overflow
  localparam logic [2:0] RS_ADD_OVF  = 3'd1;
  localparam logic [2:0] RS_ADDI_OVF = 3'd2;
  localparam logic [2:0] RS_SUB_OVF  = 3'd3;
  localparam logic [2:0] RS_MUL_OVF  = 3'd4;
  localparam logic [2:0] RS_DIV_OVF  = 3'd5;

  typedef struct packed {
    logic       hit;   // this aluop reports overflow through RSTATUS
    logic [2:0] code;
  } ovf_code_t;

  // Only add/sub/mul/div redirect to RSTATUS; other ops ignore the flag.
  function automatic ovf_code_t r_ovf_code(input logic [4:0] aluop);
    ovf_code_t r;
    r.hit  = 1'b1;
    r.code = 3'd0;
    case (aluop)
      ALU_ADD: r.code = RS_ADD_OVF;
      ALU_SUB: r.code = RS_SUB_OVF;
      ALU_MUL: r.code = RS_MUL_OVF;
      ALU_DIV: r.code = RS_DIV_OVF;
      default: r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_regfile_decode.sv
// Combinational writeback decode: turns the MEM/WB instruction and its
// results into the single register write it produces.
// Ports:
//   ir_i       instruction from the MEM/WB latch
//   o_i        ALU result (PC+1 for jal)
//   d_i        load data
//   overflow_i ALU/multdiv overflow flag
//   we_o       write enable (0 for bubbles, non-writing ops and register 0)
//   addr_o     destination register
//   data_o     write data
module wb_decode
  import wb_regfile_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RSTATUS = 30,
  parameter int LINKREG = 31
) (
  input  logic [31:0]      ir_i,
  input  logic [WIDTH-1:0] o_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             overflow_i,
  output logic             we_o,
  output logic [4:0]       addr_o,
  output logic [WIDTH-1:0] data_o
);

  logic [4:0] op;
  logic [4:0] rd;
  logic [4:0] aluop;
  ovf_code_t  oc;

  assign op    = ir_i[31:27];
  assign rd    = ir_i[26:22];
  assign aluop = ir_i[6:2];
  assign oc    = r_ovf_code(aluop);

  always_comb begin
    we_o   = 1'b0;
    addr_o = rd;
    data_o = o_i;
    case (op)
      OP_R: begin
        we_o = 1'b1;
        if (overflow_i && oc.hit) begin
          addr_o = 5'(RSTATUS);
          data_o = WIDTH'(oc.code);
        end
      end
      OP_ADDI: begin
        we_o = 1'b1;
        if (overflow_i) begin
          addr_o = 5'(RSTATUS);
          data_o = WIDTH'(RS_ADDI_OVF);
        end
      end
      OP_LW: begin
        we_o   = 1'b1;
        data_o = d_i;
      end
      OP_JAL: begin
        we_o   = 1'b1;
        addr_o = 5'(LINKREG);
      end
      OP_SETX: begin
        we_o   = 1'b1;
        addr_o = 5'(RSTATUS);
        data_o = WIDTH'(ir_i[26:0]);
      end
      default: we_o = 1'b0;
    endcase
    // A bubble decodes as R-type to $0, but an overflow flag on it must
    // not reach RSTATUS, so it is killed explicitly. $0 is never written.
    if (ir_i == '0 || addr_o == '0) we_o = 1'b0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage merged with the architectural register file.
// Commits one decoded write per falling clock edge, serves two
// combinational read ports with write-through bypass, and counts retired
// (non-bubble) instructions.
// Ports:
//   clk                  pipeline clock, state updates on the falling edge
//   clr                  asynchronous active-high reset
//   mw_ir/mw_o/mw_d      MEM/WB instruction, ALU/PC result, load data
//   mw_overflow          overflow flag for the instruction
//   rd_addr_a/b          decode read addresses
//   rd_data_a/b          read data
//   wb_we/wb_addr/wb_data decoded write, exported for bypass/hazards
//   retired              retired-instruction counter
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREG    = 32,
  parameter int RSTATUS = 30,
  parameter int LINKREG = 31,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      mw_ir,
  input  logic [WIDTH-1:0] mw_o,
  input  logic [WIDTH-1:0] mw_d,
  input  logic             mw_overflow,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [CNT_W-1:0] retired
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  wb_decode #(
    .WIDTH  (WIDTH),
    .RSTATUS(RSTATUS),
    .LINKREG(LINKREG)
  ) u_decode (
    .ir_i      (mw_ir),
    .o_i       (mw_o),
    .d_i       (mw_d),
    .overflow_i(mw_overflow),
    .we_o      (wb_we),
    .addr_o    (wb_addr),
    .data_o    (wb_data)
  );

  // Bubbles are not counted; the counter wraps silently.
  assign cnt_d = (mw_ir != '0) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_we) regs_q[wb_addr] <= wb_data;
      cnt_q <= cnt_d;
    end
  end

  // Bypass lets decode see a value in the same cycle it is being written.
  assign rd_data_a = (rd_addr_a == '0)                    ? '0      :
                     (wb_we && rd_addr_a == wb_addr)      ? wb_data :
                                                            regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0)                    ? '0      :
                     (wb_we && rd_addr_b == wb_addr)      ? wb_data :
                                                            regs_q[rd_addr_b];

  assign retired = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wbx_t;

  logic        clk = 1'b1;
  logic        clr = 1'b1;
  logic [31:0] mw_ir = '0;
  logic [31:0] mw_o = '0;
  logic [31:0] mw_d = '0;
  logic        mw_overflow = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b, wb_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] retired;

  logic [31:0] w_rda, w_rdb, w_wbdata;
  logic        w_wbwe;
  logic [4:0]  w_wbaddr;
  logic [3:0]  w_retired;

  int total = 0;
  int bad = 0;

  logic [31:0] mregs [32] = '{default: 32'd0};
  logic [31:0] mret = '0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .clr(clr), .mw_ir(mw_ir), .mw_o(mw_o), .mw_d(mw_d),
    .mw_overflow(mw_overflow), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );

  // Same design with a 4-bit counter so wraparound is reachable.
  wb_regfile #(.CNT_W(4)) u_wrap (
    .clk(clk), .clr(clr), .mw_ir(mw_ir), .mw_o(mw_o), .mw_d(mw_d),
    .mw_overflow(mw_overflow), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(w_rda), .rd_data_b(w_rdb), .wb_we(w_wbwe),
    .wb_addr(w_wbaddr), .wb_data(w_wbdata), .retired(w_retired)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write rules as a first-match table over opcode/overflow/aluop.
  function automatic wbx_t model_wb(input logic [31:0] ir, input logic [31:0] o,
                                    input logic [31:0] d, input logic ovf);
    wbx_t r;
    logic [4:0] op, alu;
    op  = ir[31:27];
    alu = ir[6:2];
    r.we = 1'b0; r.addr = ir[26:22]; r.data = o;
    if (ir == 32'd0)                       r.we = 1'b0;
    else if (op == 5'd0 && ovf && alu == 5'd0) r = '{1'b1, 5'd30, 32'd1};
    else if (op == 5'd0 && ovf && alu == 5'd1) r = '{1'b1, 5'd30, 32'd3};
    else if (op == 5'd0 && ovf && alu == 5'd6) r = '{1'b1, 5'd30, 32'd4};
    else if (op == 5'd0 && ovf && alu == 5'd7) r = '{1'b1, 5'd30, 32'd5};
    else if (op == 5'd5 && ovf)                r = '{1'b1, 5'd30, 32'd2};
    else if (op == 5'd0 || op == 5'd5)         r.we = 1'b1;
    else if (op == 5'd8)                       begin r.we = 1'b1; r.data = d; end
    else if (op == 5'd3)                       begin r.we = 1'b1; r.addr = 5'd31; end
    else if (op == 5'd21)                      r = '{1'b1, 5'd30, {5'd0, ir[26:0]}};
    if (r.addr == 5'd0) r.we = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a, input wbx_t w);
    if (a == 5'd0) return 32'd0;
    if (w.we && a == w.addr) return w.data;
    return mregs[a];
  endfunction

  // Model state update
  always @(negedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      mret <= 32'd0;
    end else begin
      wbx_t w;
      w = model_wb(mw_ir, mw_o, mw_d, mw_overflow);
      if (w.we) mregs[w.addr] <= w.data;
      if (mw_ir != 32'd0) mret <= mret + 32'd1;
    end
  end

  // Compare every cycle, mid-way between rising edge and committing edge
  always begin
    wbx_t w;
    @(posedge clk);
    #4;
    w = model_wb(mw_ir, mw_o, mw_d, mw_overflow);
    chk("cmp_wb_we", {31'd0, wb_we}, {31'd0, w.we});
    if (w.we) begin
      chk("cmp_wb_addr", {27'd0, wb_addr}, {27'd0, w.addr});
      chk("cmp_wb_data", wb_data, w.data);
    end
    chk("cmp_rd_a", rd_data_a, model_rd(rd_addr_a, w));
    chk("cmp_rd_b", rd_data_b, model_rd(rd_addr_b, w));
    chk("cmp_retired", retired, mret);
    chk("cmp_wrap_retired", {28'd0, w_retired}, {28'd0, mret[3:0]});
  end

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [16:0] imm);
    return {op, rd, 5'd0, imm};
  endfunction

  task automatic present(input logic [31:0] ir, input logic [31:0] o,
                         input logic [31:0] d, input logic ovf);
    @(posedge clk);
    #1;
    mw_ir = ir; mw_o = o; mw_d = d; mw_overflow = ovf;
  endtask

  task automatic finish_commit();
    @(negedge clk);
    #1;
    mw_ir = 32'd0; mw_overflow = 1'b0;
  endtask

  task automatic commit(input logic [31:0] ir, input logic [31:0] o,
                        input logic [31:0] d, input logic ovf);
    present(ir, o, d, ovf);
    finish_commit();
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string nm);
    rd_addr_a = a;
    #1;
    chk(nm, rd_data_a, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("reset_retired", retired, 32'd0);
    peek(5'd30, 32'd0, "reset_r30");

    commit(itype(5'b00101, 5'd5, 17'd7), 32'd7, 32'd0, 1'b0);
    peek(5'd5, 32'd7, "addi_r5");
    chk("addi_retired", retired, 32'd1);

    commit(itype(5'b01000, 5'd6, 17'd0), 32'd0, 32'hDEADBEEF, 1'b0);
    peek(5'd6, 32'hDEADBEEF, "lw_r6");

    commit(rtype(5'd7, 5'b00000), 32'h1234, 32'd0, 1'b1);
    peek(5'd30, 32'd1, "add_ovf_r30");
    peek(5'd7, 32'd0, "add_ovf_r7");

    commit(itype(5'b00101, 5'd8, 17'd3), 32'h5678, 32'd0, 1'b1);
    peek(5'd30, 32'd2, "addi_ovf_r30");
    peek(5'd8, 32'd0, "addi_ovf_r8");

    commit(rtype(5'd9, 5'b00111), 32'h9ABC, 32'd0, 1'b1);
    peek(5'd30, 32'd5, "div_ovf_r30");
    peek(5'd9, 32'd0, "div_ovf_r9");

    // Overflow on an aluop without a status code is ignored
    commit(rtype(5'd10, 5'b00010), 32'h55, 32'd0, 1'b1);
    peek(5'd10, 32'h55, "and_ovf_r10");
    peek(5'd30, 32'd5, "and_ovf_r30");

    commit({5'b00011, 27'h0000123}, 32'h42, 32'd0, 1'b0);
    peek(5'd31, 32'h42, "jal_r31");

    commit({5'b10101, 27'h7FFFFFF}, 32'd0, 32'd0, 1'b0);
    peek(5'd30, 32'h07FFFFFF, "setx_r30");

    // Write to $0
    present(itype(5'b00101, 5'd0, 17'd9), 32'h99, 32'd0, 1'b0);
    #1;
    chk("r0_wb_we", {31'd0, wb_we}, 32'd0);
    chk("r0_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("r0_wb_data", wb_data, 32'h99);
    finish_commit();
    peek(5'd0, 32'd0, "r0_read");

    // Same-cycle bypass
    present(itype(5'b00101, 5'd9, 17'd1), 32'h11, 32'd0, 1'b0);
    rd_addr_a = 5'd9; rd_addr_b = 5'd0;
    #1;
    chk("bypass_a", rd_data_a, 32'h11);
    chk("bypass_b", rd_data_b, 32'd0);
    finish_commit();
    peek(5'd9, 32'h11, "bypass_r9_stored");

    // Counter: 10 commits so far, then 10 bubbles and 3 stores
    for (int i = 0; i < 10; i++) commit(32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) commit(itype(5'b00111, 5'd4, 17'd0), 32'd0, 32'd0, 1'b0);
    chk("cnt_after_sw", retired, 32'd13);
    peek(5'd4, 32'd0, "sw_no_write");

    // Asynchronous reset mid-cycle, between edges
    @(posedge clk);
    #1 clr = 1'b1;
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    #1;
    chk("mid_reset_a", rd_data_a, 32'd0);
    chk("mid_reset_b", rd_data_b, 32'd0);
    chk("mid_reset_retired", retired, 32'd0);
    clr = 1'b0;

    // Wrap: 4-bit counter reaches all-ones after 15, then 0
    for (int i = 0; i < 15; i++) commit(itype(5'b00111, 5'd4, 17'd0), 32'd0, 32'd0, 1'b0);
    chk("wrap_all_ones", {28'd0, w_retired}, 32'd15);
    commit(itype(5'b00111, 5'd4, 17'd0), 32'd0, 32'd0, 1'b0);
    chk("wrap_zero", {28'd0, w_retired}, 32'd0);
    chk("wrap_main_cnt", retired, 32'd16);

    @(posedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
